// File: rtl/fano_out_serializer.sv
// Output stage for one fano_decoder channel: buffers decoded words in a FIFO and
// streams them MSB-byte-first over a byte-wide AXI-Stream master with framed tlast.
module fano_out_serializer #(
    parameter int NOB_WIDTH   = 4,
    parameter int FIFO_DEPTH  = 16,
    parameter int FRAME_BYTES = 188,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_vld,
    input  logic [8*NOB_WIDTH-1:0]       i_dec_data,
    input  logic                         i_flush,
    input  logic                         i_clr_stat,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [7:0]                   m_axis_tdata,
    output logic                         m_axis_tlast,
    output logic [$clog2(FIFO_DEPTH):0]  o_fifo_level,
    output logic                         o_overflow,
    output logic [CNT_WIDTH-1:0]         o_ovf_cnt
);
    localparam int WORD_W = 8 * NOB_WIDTH;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int IDX_W  = (NOB_WIDTH > 1) ? $clog2(NOB_WIDTH) : 1;
    localparam int FRM_W  = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WORD_W-1:0]    r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [LVL_W-1:0]     r_level;
    logic [WORD_W-1:0]    r_shift;
    logic [IDX_W-1:0]     r_byte_idx;
    logic [FRM_W-1:0]     r_frame_cnt;
    logic                 r_tvalid;
    logic                 r_overflow;
    logic [CNT_WIDTH-1:0] r_ovf_cnt;

    logic w_fifo_empty;
    logic w_fifo_full;
    logic w_push;
    logic w_drop;
    logic w_hs;
    logic w_last_byte;
    logic w_pop;
    logic w_shift_en;
    logic w_tvalid_nxt;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Room is judged on last cycle's level, so a same-cycle pop never frees a slot.
    assign w_fifo_empty = (r_level == '0);
    assign w_fifo_full  = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_push       = i_vld && !i_flush && !w_fifo_full;
    assign w_drop       = i_vld && !i_flush && w_fifo_full;
    assign w_hs         = r_tvalid && m_axis_tready;
    assign w_last_byte  = (r_byte_idx == IDX_W'(NOB_WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        w_shift_en   = 1'b0;
        w_tvalid_nxt = r_tvalid;
        if (i_flush) begin
            w_state_nxt  = IDLE;
            w_tvalid_nxt = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_tvalid_nxt = 1'b1;
                        w_state_nxt  = SEND;
                    end
                end
                SEND: begin
                    if (w_hs) begin
                        if (!w_last_byte) begin
                            w_shift_en = 1'b1;
                        end else if (!w_fifo_empty) begin
                            w_pop = 1'b1;
                        end else begin
                            w_tvalid_nxt = 1'b0;
                            w_state_nxt  = IDLE;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Word FIFO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_dec_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Byte serializer and frame counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift     <= '0;
            r_byte_idx  <= '0;
            r_frame_cnt <= '0;
            r_tvalid    <= 1'b0;
        end else begin
            r_tvalid <= w_tvalid_nxt;
            if (i_flush) begin
                r_byte_idx  <= '0;
                r_frame_cnt <= '0;
            end else begin
                if (w_pop) begin
                    r_shift    <= r_mem[r_rd_ptr];
                    r_byte_idx <= '0;
                end else if (w_shift_en) begin
                    r_shift    <= r_shift << 8;
                    r_byte_idx <= r_byte_idx + IDX_W'(1);
                end
                if (w_hs) begin
                    r_frame_cnt <= (r_frame_cnt == FRM_W'(FRAME_BYTES - 1)) ? '0
                                                                             : r_frame_cnt + FRM_W'(1);
                end
            end
        end
    end

    // Overflow statistics; a drop outranks a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_ovf_cnt  <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            r_ovf_cnt  <= i_clr_stat ? CNT_WIDTH'(1) : sat_inc(r_ovf_cnt);
        end else if (i_clr_stat) begin
            r_overflow <= 1'b0;
            r_ovf_cnt  <= '0;
        end
    end

    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tdata  = r_shift[WORD_W-1 -: 8];
    assign m_axis_tlast  = r_tvalid && (r_frame_cnt == FRM_W'(FRAME_BYTES - 1));
    assign o_fifo_level  = r_level;
    assign o_overflow    = r_overflow;
    assign o_ovf_cnt     = r_ovf_cnt;

endmodule

// File: tb/tb_fano_out_serializer.sv
// Scoreboard bench for fano_out_serializer: expected bytes are queued as words are
// driven and compared, with a frame model for tlast, when the sink accepts them.
module tb_fano_out_serializer;
    localparam int NOB   = 4;
    localparam int DEPTH = 16;
    localparam int FRAME = 6;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          i_vld = 1'b0;
    logic [31:0]   i_dec_data = '0;
    logic          i_flush = 1'b0;
    logic          i_clr_stat = 1'b0;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic [7:0]    m_axis_tdata;
    logic          m_axis_tlast;
    logic [4:0]    o_fifo_level;
    logic          o_overflow;
    logic [CW-1:0] o_ovf_cnt;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  exp_q[$];
    int          frame_m = 0;
    int          byte_no = 0;
    logic [15:0] tl_mask = '0;

    fano_out_serializer #(
        .NOB_WIDTH(NOB), .FIFO_DEPTH(DEPTH), .FRAME_BYTES(FRAME), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset), .i_vld(i_vld), .i_dec_data(i_dec_data),
        .i_flush(i_flush), .i_clr_stat(i_clr_stat),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .o_fifo_level(o_fifo_level), .o_overflow(o_overflow), .o_ovf_cnt(o_ovf_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1);
    end

    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (reset || i_flush) begin
                exp_q.delete();
                frame_m = 0;
                byte_no = 0;
                tl_mask = '0;
            end else if (m_axis_tvalid && m_axis_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra_byte: got %h, required no byte", m_axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    if (m_axis_tdata !== e) begin
                        errors++;
                        $display("FAIL sb_tdata: byte %0d got %h, required %h", byte_no, m_axis_tdata, e);
                    end
                end
                checks++;
                if (m_axis_tlast !== 1'(frame_m == FRAME - 1)) begin
                    errors++;
                    $display("FAIL sb_tlast: byte %0d got %b, required %b", byte_no, m_axis_tlast, frame_m == FRAME - 1);
                end
                if (byte_no < 16) tl_mask[byte_no] = m_axis_tlast;
                byte_no++;
                frame_m = (frame_m == FRAME - 1) ? 0 : frame_m + 1;
            end
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit accept);
        i_vld = 1'b1;
        i_dec_data = w;
        if (accept) for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
        @(posedge clk); #1;
        i_vld = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        int n = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 8'h00 || m_axis_tlast !== 1'b0) begin
            errors++;
            $display("FAIL reset_axis: got v=%b d=%h l=%b, required 0 00 0", m_axis_tvalid, m_axis_tdata, m_axis_tlast);
        end
        checks++;
        if (o_fifo_level !== 5'd0 || o_overflow !== 1'b0 || o_ovf_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_stat: got lvl=%0d ovf=%b cnt=%0d, required 0 0 0", o_fifo_level, o_overflow, o_ovf_cnt);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || o_fifo_level !== 5'd0) begin
            errors++;
            $display("FAIL reset_release: got v=%b lvl=%0d, required 0 0", m_axis_tvalid, o_fifo_level);
        end
    endtask

    task automatic test_single_word();
        m_axis_tready = 1'b1;
        send_word(32'hA1B2C3D4, 1'b1);
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL single_latency_early: got tvalid=%b after 1 clk, required 0", m_axis_tvalid);
        end
        @(posedge clk); #1;
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'hA1) begin
            errors++;
            $display("FAIL single_latency: got v=%b d=%h after 2 clks, required 1 a1", m_axis_tvalid, m_axis_tdata);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL single_done: got v=%b left=%0d, required 0 0", m_axis_tvalid, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int bubbles = 0;
        logic [31:0] w;
        m_axis_tready = 1'b1;
        for (int cyc = 0; cyc < 26; cyc++) begin
            if (cyc % 4 == 0 && cyc < 24) begin
                w = 32'h11223344 ^ (32'(cyc) * 32'h01010101);
                i_vld = 1'b1;
                i_dec_data = w;
                for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
            end
            @(posedge clk); #1;
            i_vld = 1'b0;
            if (cyc >= 1 && cyc <= 24 && m_axis_tvalid !== 1'b1) bubbles++;
        end
        checks++;
        if (bubbles != 0) begin
            errors++;
            $display("FAIL b2b_bubbles: got %0d idle cycles, required 0", bubbles);
        end
        checks++;
        if (m_axis_tvalid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_done: got v=%b left=%0d, required 0 0", m_axis_tvalid, exp_q.size());
        end
        checks++;
        if (o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_overflow: got %b, required 0", o_overflow);
        end
    endtask

    task automatic test_backpressure();
        m_axis_tready = 1'b0;
        for (int k = 0; k < 18; k++) begin
            send_word(32'h10203040 + 32'(k) * 32'h01010101, k < 17);
            if (k == 1) begin
                checks++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h10) begin
                    errors++;
                    $display("FAIL bp_first: got v=%b d=%h, required 1 10", m_axis_tvalid, m_axis_tdata);
                end
            end
            if (k == 15) begin
                checks++;
                if (o_fifo_level !== 5'd15) begin
                    errors++;
                    $display("FAIL bp_level15: got %0d, required 15", o_fifo_level);
                end
            end
            if (k == 16) begin
                checks++;
                if (o_fifo_level !== 5'd16 || o_overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_full: got lvl=%0d ovf=%b, required 16 0", o_fifo_level, o_overflow);
                end
            end
        end
        checks++;
        if (o_overflow !== 1'b1 || o_ovf_cnt !== 16'd1 || o_fifo_level !== 5'd16) begin
            errors++;
            $display("FAIL bp_drop: got ovf=%b cnt=%0d lvl=%0d, required 1 1 16", o_overflow, o_ovf_cnt, o_fifo_level);
        end
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h10 || m_axis_tlast !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: got v=%b d=%h l=%b, required 1 10 0", m_axis_tvalid, m_axis_tdata, m_axis_tlast);
        end
        send_word(32'hDEADBEEF, 1'b0);
        checks++;
        if (o_ovf_cnt !== 16'd2) begin
            errors++;
            $display("FAIL bp_drop2: got cnt=%0d, required 2", o_ovf_cnt);
        end
        i_clr_stat = 1'b1;
        send_word(32'hCAFEF00D, 1'b0);
        i_clr_stat = 1'b0;
        checks++;
        if (o_overflow !== 1'b1 || o_ovf_cnt !== 16'd1) begin
            errors++;
            $display("FAIL clr_vs_drop: got ovf=%b cnt=%0d, required 1 1", o_overflow, o_ovf_cnt);
        end
        i_clr_stat = 1'b1;
        @(posedge clk); #1;
        i_clr_stat = 1'b0;
        checks++;
        if (o_overflow !== 1'b0 || o_ovf_cnt !== 16'd0) begin
            errors++;
            $display("FAIL clr_stat: got ovf=%b cnt=%0d, required 0 0", o_overflow, o_ovf_cnt);
        end
        m_axis_tready = 1'b1;
        wait_drain(150);
        checks++;
        if (m_axis_tvalid !== 1'b0 || exp_q.size() != 0 || o_fifo_level !== 5'd0) begin
            errors++;
            $display("FAIL bp_drain: got v=%b left=%0d lvl=%0d, required 0 0 0", m_axis_tvalid, exp_q.size(), o_fifo_level);
        end
    endtask

    task automatic test_frame_tlast();
        i_flush = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0;
        m_axis_tready = 1'b1;
        for (int w = 0; w < 3; w++) begin
            send_word(32'h0A0B0C0D + 32'(w) * 32'h10101010, 1'b1);
            repeat (3) @(posedge clk);
            #1;
        end
        wait_drain(30);
        checks++;
        if (tl_mask !== 16'h0820 || byte_no != 12) begin
            errors++;
            $display("FAIL frame_tlast: got mask=%h bytes=%0d, required 0820 12", tl_mask, byte_no);
        end
    endtask

    task automatic test_flush();
        logic [CW-1:0] snap;
        m_axis_tready = 1'b0;
        for (int k = 0; k < 5; k++) send_word(32'hF0E0D0C0 + 32'(k), 1'b1);
        m_axis_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        snap = o_ovf_cnt;
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'hD0 || o_fifo_level === 5'd0) begin
            errors++;
            $display("FAIL flush_pre: got v=%b d=%h lvl=%0d, required 1 d0 nonzero", m_axis_tvalid, m_axis_tdata, o_fifo_level);
        end
        i_flush = 1'b1;
        i_vld = 1'b1;
        i_dec_data = 32'hBAD0BAD0;
        @(posedge clk); #1;
        i_flush = 1'b0;
        i_vld = 1'b0;
        checks++;
        if (m_axis_tvalid !== 1'b0 || o_fifo_level !== 5'd0 || o_ovf_cnt !== snap) begin
            errors++;
            $display("FAIL flush_now: got v=%b lvl=%0d cnt=%0d, required 0 0 %0d", m_axis_tvalid, o_fifo_level, o_ovf_cnt, snap);
        end
        @(posedge clk); #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || o_fifo_level !== 5'd0) begin
            errors++;
            $display("FAIL flush_vld_discard: got v=%b lvl=%0d, required 0 0", m_axis_tvalid, o_fifo_level);
        end
        for (int w = 0; w < 2; w++) begin
            send_word(32'h61626364 + 32'(w) * 32'h01010101, 1'b1);
            repeat (3) @(posedge clk);
            #1;
        end
        wait_drain(30);
        checks++;
        if (tl_mask !== 16'h0020 || byte_no != 8) begin
            errors++;
            $display("FAIL flush_frame_restart: got mask=%h bytes=%0d, required 0020 8", tl_mask, byte_no);
        end
    endtask

    task automatic test_async_reset();
        m_axis_tready = 1'b1;
        send_word(32'h01020304, 1'b1);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 8'h00 || m_axis_tlast !== 1'b0 || o_fifo_level !== 5'd0) begin
            errors++;
            $display("FAIL async_reset: got v=%b d=%h l=%b lvl=%0d, required 0 00 0 0", m_axis_tvalid, m_axis_tdata, m_axis_tlast, o_fifo_level);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        send_word(32'h5A6B7C8D, 1'b1);
        @(posedge clk); #1;
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h5A) begin
            errors++;
            $display("FAIL post_reset_first: got v=%b d=%h, required 1 5a", m_axis_tvalid, m_axis_tdata);
        end
        wait_drain(20);
        checks++;
        if (exp_q.size() != 0 || byte_no != 4 || m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_drain: got left=%0d bytes=%0d v=%b, required 0 4 0", exp_q.size(), byte_no, m_axis_tvalid);
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_frame_tlast();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
